// File: rtl/if_fetch_queue.sv
// if_fetch_queue: RISC-V fetch stage (PC generation, ROM request, DEPTH-entry return queue).
// Optional JAL pre-decoder enabled by defining IF_JAL_PREDECODE_EN.

module if_fetch_queue_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk_i,
  input logic          rst_i,
  input logic          wr_en_i,
  input logic [CW-1:0] count_i
);
  // A returning word must always find a free slot; the issue credit guarantees it.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    wr_en_i |-> (count_i < CW'(DEPTH)));
endmodule

module if_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_inst_o,
  output logic            id_pred_taken_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0]   LAST_PTR   = PW'(DEPTH - 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [XLEN-1:0] inst_mem_q [DEPTH];

  logic [CW:0]     occ_s;
  logic            credit_ok_s;
  logic            wr_en_s;
  logic            rd_en_s;
  logic            jal_hit_s;
  logic [XLEN-1:0] jal_target_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == LAST_PTR) begin
      n = {PW{1'b0}};
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  assign occ_s       = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign credit_ok_s = occ_s < (CW+1)'(DEPTH);
  assign imem_req_o  = !rst_i && (redirect_valid_i || credit_ok_s);
  assign imem_addr_o = redirect_valid_i ? (redirect_pc_i & ALIGN_MASK) : fetch_pc_q;
  assign wr_en_s     = inflight_q && !drop_q && !redirect_valid_i;
  assign rd_en_s     = id_valid_o && id_ready_i && !redirect_valid_i;

  assign id_valid_o  = (count_q != {CW{1'b0}});
  assign id_pc_o     = pc_mem_q[rd_ptr_q];
  assign id_inst_o   = inst_mem_q[rd_ptr_q];

`ifdef IF_JAL_PREDECODE_EN
  logic pred_mem_q [DEPTH];

  // J-immediate decode of the returning word
  always_comb begin
    jal_hit_s    = wr_en_s && (imem_rdata_i[6:0] == 7'b1101111);
    jal_target_s = (inflight_pc_q + {{(XLEN-21){imem_rdata_i[31]}}, imem_rdata_i[31],
                    imem_rdata_i[19:12], imem_rdata_i[20], imem_rdata_i[30:21], 1'b0})
                   & ALIGN_MASK;
  end

  assign id_pred_taken_o = pred_mem_q[rd_ptr_q];
`else
  assign jal_hit_s       = 1'b0;
  assign jal_target_s    = {XLEN{1'b0}};
  assign id_pred_taken_o = 1'b0;
`endif

  // Next-state for fetch PC, in-flight tracking and queue pointers
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = imem_req_o;
    inflight_pc_d = inflight_pc_q;
    drop_d        = imem_req_o && jal_hit_s;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (jal_hit_s) begin
      fetch_pc_d = jal_target_s;
    end else if (imem_req_o) begin
      fetch_pc_d = imem_addr_o + XLEN'(4);
    end else begin
      fetch_pc_d = fetch_pc_q;
    end

    if (imem_req_o) begin
      inflight_pc_d = imem_addr_o;
    end else begin
      inflight_pc_d = inflight_pc_q;
    end

    // Redirect voids any enqueue/dequeue and empties the queue
    if (redirect_valid_i) begin
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      wr_ptr_d = wr_en_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = rd_en_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      case ({wr_en_s, rd_en_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State and queue storage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q    <= RESET_PC;
      rd_ptr_q      <= {PW{1'b0}};
      wr_ptr_q      <= {PW{1'b0}};
      count_q       <= {CW{1'b0}};
      inflight_q    <= 1'b0;
      inflight_pc_q <= {XLEN{1'b0}};
      drop_q        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= {XLEN{1'b0}};
        inst_mem_q[i] <= {XLEN{1'b0}};
`ifdef IF_JAL_PREDECODE_EN
        pred_mem_q[i] <= 1'b0;
`endif
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      drop_q        <= drop_d;
      if (wr_en_s) begin
        pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
        inst_mem_q[wr_ptr_q] <= imem_rdata_i;
`ifdef IF_JAL_PREDECODE_EN
        pred_mem_q[wr_ptr_q] <= jal_hit_s;
`endif
      end
    end
  end

  if_fetch_queue_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en_i (wr_en_s),
    .count_i (count_q)
  );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios plus a randomized run,
// scored against a program-order stream model (next PC = +4, redirect target, or JAL target).

module tb_if_fetch_queue;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redir_v = 1'b0;
  logic [31:0] redir_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_pred;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc = RST_PC;
  logic        jal_on = 1'b0;

  if_fetch_queue dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .redirect_valid_i (redir_v),
    .redirect_pc_i    (redir_pc),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_rdata_i     (imem_rdata),
    .id_valid_o       (id_valid),
    .id_ready_i       (id_ready),
    .id_pc_o          (id_pc),
    .id_inst_o        (id_inst),
    .id_pred_taken_o  (id_pred)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (jal_on && a == 32'h0000_0010) return 32'h0400_006F;  // jal x0, +0x40
    return {a[26:2], 7'h13};
  endfunction

  function automatic logic is_jal(input logic [31:0] w);
`ifdef IF_JAL_PREDECODE_EN
    return w[6:0] == 7'h6F;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    logic [31:0] w;
    logic [31:0] imm;
    w   = rom(pc);
    imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    if (is_jal(w)) return (pc + imm) & 32'hFFFF_FFFC;
    return pc + 32'd4;
  endfunction

  // ROM answers one cycle after each accepted request
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= rom(imem_addr);
  end

  // Advance the stream model by the current cycle's events, then move to the next cycle
  task automatic step();
    if (rst) exp_pc = RST_PC;
    else if (redir_v) exp_pc = redir_pc & 32'hFFFF_FFFC;
    else if (id_valid && id_ready) exp_pc = next_pc(exp_pc);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; redir_v = 1'b0; id_ready = 1'b1;
    @(negedge clk);
    step(); step();
    #1;
    checks += 5;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0h exp=0", imem_req); end
    if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", id_valid); end
    if (id_pc !== 32'h0 || id_inst !== 32'h0) begin
      failures++; $display("FAIL rst_head got=%0h/%0h exp=0/0", id_pc, id_inst);
    end
    if (id_pred !== 1'b0) begin failures++; $display("FAIL rst_pred got=%0h exp=0", id_pred); end
    if (imem_addr !== RST_PC) begin failures++; $display("FAIL rst_addr got=%0h exp=%0h", imem_addr, RST_PC); end
    step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks += 2;
      if (imem_req !== 1'b1 || imem_addr !== RST_PC + 32'(4 * k)) begin
        failures++; $display("FAIL seq_addr c%0d got=%0h/%0h exp=1/%0h", k, imem_req, imem_addr, RST_PC + 32'(4 * k));
      end
      if (id_valid !== (k >= 2)) begin
        failures++; $display("FAIL seq_valid c%0d got=%0h exp=%0h", k, id_valid, (k >= 2));
      end
      if (k >= 2) begin
        checks++;
        if (id_pc !== RST_PC + 32'(4 * (k - 2)) || id_inst !== rom(RST_PC + 32'(4 * (k - 2)))) begin
          failures++; $display("FAIL seq_head c%0d got=%0h/%0h exp=%0h", k, id_pc, id_inst, RST_PC + 32'(4 * (k - 2)));
        end
      end
      step();
    end
  endtask

  task automatic test_stall();
    logic [31:0] frozen;
    int          n_req;
    frozen = exp_pc;
    n_req  = 0;
    id_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (imem_req) n_req++;
      checks++;
      if (id_valid !== 1'b1 || id_pc !== frozen) begin
        failures++; $display("FAIL stall_head c%0d got=%0h/%0h exp=1/%0h", k, id_valid, id_pc, frozen);
      end
      step();
    end
    checks += 2;
    if (n_req != 2) begin failures++; $display("FAIL stall_credit got=%0d exp=2", n_req); end
    #1;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req got=%0h exp=0", imem_req); end
    id_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (id_valid !== 1'b1 || id_pc !== frozen + 32'(4 * k) || id_inst !== rom(id_pc)) begin
        failures++; $display("FAIL stall_drain c%0d got=%0h/%0h exp=1/%0h", k, id_valid, id_pc, frozen + 32'(4 * k));
      end
      step();
    end
  endtask

  task automatic test_redirect(input logic rdy_at_redir, input logic [31:0] tgt);
    logic [31:0] base;
    id_ready = rdy_at_redir;
    step(); step(); step();
    redir_v = 1'b1; redir_pc = tgt;
    base = tgt & 32'hFFFF_FFFC;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== base) begin
      failures++; $display("FAIL redir_addr got=%0h/%0h exp=1/%0h", imem_req, imem_addr, base);
    end
    step();
    redir_v = 1'b0; id_ready = 1'b1;
    #1;
    checks++;
    if (id_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%0h exp=0", id_valid); end
    step();
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (id_valid !== 1'b1 || id_pc !== base + 32'(4 * k) || id_pc !== exp_pc || id_inst !== rom(base + 32'(4 * k))) begin
        failures++; $display("FAIL redir_stream c%0d got=%0h/%0h exp=1/%0h", k, id_valid, id_pc, base + 32'(4 * k));
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    redir_v = 1'b1; redir_pc = 32'h200;
    step();
    redir_pc = 32'h300;
    #1;
    checks++;
    if (imem_addr !== 32'h300) begin failures++; $display("FAIL b2b_addr got=%0h exp=300", imem_addr); end
    step();
    redir_v = 1'b0;
    #1;
    checks++;
    if (id_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%0h exp=0", id_valid); end
    step();
    #1;
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h300) begin
      failures++; $display("FAIL b2b_first got=%0h/%0h exp=1/300", id_valid, id_pc);
    end
    step();
  endtask

  task automatic test_jal();
    int jal_cyc;
    int seen14;
    jal_cyc = -1; seen14 = 0;
    jal_on = 1'b1;
    redir_v = 1'b1; redir_pc = 32'h0; id_ready = 1'b1;
    step();
    redir_v = 1'b0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (id_valid) begin
        checks++;
        if (id_pc !== exp_pc || id_inst !== rom(exp_pc) || id_pred !== is_jal(rom(exp_pc))) begin
          failures++; $display("FAIL jal_stream c%0d got=%0h/%0h exp=%0h/%0h", c, id_pc, id_pred, exp_pc, is_jal(rom(exp_pc)));
        end
        if (id_pc == 32'h14) seen14++;
        if (id_pc == 32'h10 && jal_cyc < 0) jal_cyc = c;
      end
`ifdef IF_JAL_PREDECODE_EN
      if (jal_cyc >= 0 && c == jal_cyc + 1) begin
        checks++;
        if (id_valid !== 1'b0) begin failures++; $display("FAIL jal_bubble got=%0h exp=0", id_valid); end
      end
      if (jal_cyc >= 0 && c == jal_cyc + 2) begin
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h50) begin
          failures++; $display("FAIL jal_target got=%0h/%0h exp=1/50", id_valid, id_pc);
        end
      end
`else
      if (jal_cyc >= 0 && c == jal_cyc + 1) begin
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h14) begin
          failures++; $display("FAIL jal_fallthru got=%0h/%0h exp=1/14", id_valid, id_pc);
        end
      end
`endif
      step();
    end
    checks++;
    if (jal_cyc < 0) begin failures++; $display("FAIL jal_seen got=none exp=10"); end
`ifdef IF_JAL_PREDECODE_EN
    checks++;
    if (seen14 != 0) begin failures++; $display("FAIL jal_skip got=%0d exp=0", seen14); end
`endif
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL midrst_req got=%0h exp=0", imem_req); end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      failures++; $display("FAIL midrst_state got=%0h/%0h/%0h exp=0/1/%0h", id_valid, imem_req, imem_addr, RST_PC);
    end
    step(); step();
    #1;
    checks++;
    if (id_valid !== 1'b1 || id_pc !== RST_PC) begin
      failures++; $display("FAIL midrst_first got=%0h/%0h exp=1/%0h", id_valid, id_pc, RST_PC);
    end
    step();
  endtask

  task automatic test_random();
    int n_hs;
    n_hs = 0;
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      redir_v  = ($urandom_range(0, 99) < 6);
      redir_pc = 32'($urandom_range(0, 32'h3FF));
      id_ready = ($urandom_range(0, 99) < 70);
      #1;
      if (!rst && !redir_v && id_valid && id_ready) begin
        n_hs++;
        checks++;
        if (id_pc !== exp_pc || id_inst !== rom(exp_pc) || id_pred !== is_jal(rom(exp_pc))) begin
          failures++; $display("FAIL rand_head c%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", c,
                               id_pc, id_inst, id_pred, exp_pc, rom(exp_pc), is_jal(rom(exp_pc)));
        end
      end
      checks++;
      if ((rst && imem_req !== 1'b0) || (imem_req && imem_addr[1:0] !== 2'b00)) begin
        failures++; $display("FAIL rand_req c%0d got=%0h/%0h exp=aligned,idle_in_reset", c, imem_req, imem_addr);
      end
      step();
    end
    rst = 1'b0; redir_v = 1'b0; id_ready = 1'b1;
    checks++;
    if (n_hs < 50) begin failures++; $display("FAIL rand_progress got=%0d exp>=50", n_hs); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect(1'b0, 32'h103);
    test_redirect(1'b1, 32'h180);
    test_back_to_back();
    test_jal();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
